// File: rtl/fetch_ctrl.sv
// Instruction fetch / issue / retire sequencer: fetches at pc, holds the word for
// decode, waits for execute, then pulses the PC update with the chosen next-PC source.
package fetch_ctrl_pkg;
  typedef enum logic [1:0] {
    PC_4   = 2'b00,
    PC_BEQ = 2'b01,
    PC_J   = 2'b10
  } PC_sel_e;
endpackage

module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  input  logic        instr_ready,
  input  logic        ex_done,
  input  PC_sel_e     ex_pc_sel,
  output logic        pc_en,
  output PC_sel_e     pc_sel,
  output logic [31:0] retired,
  output logic        err,
  output logic [2:0]  dbg_state
);

  // Handshakes: imem request is held until the cycle imem_gnt=1; data is taken on the
  // cycle imem_rvalid=1 in FETCH_WAIT; instr transfers on the edge with instr_valid=1
  // and instr_ready=1; ex_done is honoured only in EXEC_WAIT. All are single-edge events.
  typedef enum logic [2:0] {
    FETCH_REQ  = 3'd0,
    FETCH_WAIT = 3'd1,
    ISSUE      = 3'd2,
    EXEC_WAIT  = 3'd3,
    PC_UPDATE  = 3'd4,
    ERROR      = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] instr_q;
  logic [31:0] retired_q;
  PC_sel_e     sel_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH_REQ;
      wait_q    <= 8'd0;
      instr_q   <= 32'd0;
      retired_q <= 32'd0;
      sel_q     <= PC_4;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == FETCH_WAIT && imem_rvalid) instr_q <= imem_rdata;
      if (state_q == EXEC_WAIT && ex_done) begin
        case (ex_pc_sel)
          PC_4, PC_BEQ, PC_J: sel_q <= ex_pc_sel;
          default:            sel_q <= PC_4;
        endcase
      end
      if (state_q == PC_UPDATE) retired_q <= retired_q + 32'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      FETCH_REQ: begin
        if (imem_gnt) begin
          state_d = FETCH_WAIT;
          wait_d  = 8'd0;
        end
      end
      FETCH_WAIT: begin
        // rvalid wins even on the cycle that would otherwise time out
        if (imem_rvalid) begin
          state_d = ISSUE;
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_d == 8'(TIMEOUT)) state_d = ERROR;
        end
      end
      ISSUE:     if (instr_ready) state_d = EXEC_WAIT;
      EXEC_WAIT: if (ex_done) state_d = PC_UPDATE;
      PC_UPDATE: state_d = FETCH_REQ;
      ERROR:     state_d = ERROR;
      default:   state_d = FETCH_REQ;
    endcase
  end

  assign imem_req    = (state_q == FETCH_REQ) && !rst;
  assign imem_addr   = pc;
  assign instr_valid = (state_q == ISSUE);
  assign instr       = instr_q;
  assign pc_en       = (state_q == PC_UPDATE);
  assign pc_sel      = pc_en ? sel_q : PC_4;
  assign retired     = retired_q;
  assign err         = (state_q == ERROR);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: phase-by-phase instruction transactions with randomized
// delays and noise on ignored inputs, checked against an instruction-level model.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam int TIMEOUT = 16;

  logic        clk, rst;
  logic [31:0] pc;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, instr_ready, ex_done;
  logic [31:0] instr, retired;
  PC_sel_e     ex_pc_sel, pc_sel;
  logic        pc_en, err;
  logic [2:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_retired;
  logic [31:0] model_pc;

  fetch_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .pc(pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .ex_done(ex_done), .ex_pc_sel(ex_pc_sel),
    .pc_en(pc_en), .pc_sel(pc_sel), .retired(retired), .err(err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

  // next-PC source as execute requested it; the unused code falls back to PC_4
  function automatic logic [1:0] exp_sel(input logic [1:0] s);
    return (s == 2'b11) ? 2'b00 : s;
  endfunction

  // drivers
  task automatic noise();
    imem_gnt    = 1'($urandom);
    imem_rvalid = 1'($urandom);
    imem_rdata  = $urandom;
    instr_ready = 1'($urandom);
    ex_done     = 1'($urandom);
    ex_pc_sel   = PC_sel_e'($urandom_range(0, 3));
  endtask

  task automatic quiet();
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    instr_ready = 0; ex_done = 0; ex_pc_sel = PC_4;
  endtask

  task automatic do_req(input int gd);
    logic [31:0] addr0;
    addr0 = model_pc;
    for (int i = 0; i <= gd; i++) begin
      @(negedge clk);
      n_vec++;
      if ({imem_req, instr_valid, pc_en, err} !== 4'b1000 || imem_addr !== addr0 || pc_sel !== PC_4) begin
        n_err++;
        $display("FAIL fetch_req: req/ivalid/pc_en/err=%b%b%b%b addr=%h pc_sel=%0d, expected 1000 addr=%h pc_sel=0",
                 imem_req, instr_valid, pc_en, err, imem_addr, pc_sel, addr0);
      end
      n_vec++;
      if (retired !== model_retired) begin
        n_err++;
        $display("FAIL retired: got %h expected %h", retired, model_retired);
      end
      noise();
      imem_gnt = (i == gd);
    end
  endtask

  task automatic do_wait(input int rd, input logic [31:0] data);
    for (int i = 0; i <= rd; i++) begin
      @(negedge clk);
      n_vec++;
      if ({imem_req, instr_valid, pc_en, err} !== 4'b0000) begin
        n_err++;
        $display("FAIL fetch_wait: req/ivalid/pc_en/err=%b%b%b%b expected 0000 (wait cycle %0d)",
                 imem_req, instr_valid, pc_en, err, i);
      end
      noise();
      imem_rvalid = (i == rd);
      if (i == rd) begin
        imem_rdata = data;
        exp_q.push_back(data);
      end
    end
  endtask

  task automatic do_issue(input int yd);
    for (int i = 0; i <= yd; i++) begin
      @(negedge clk);
      n_vec++;
      if ({imem_req, instr_valid, pc_en} !== 3'b010 || instr !== exp_q[0]) begin
        n_err++;
        $display("FAIL issue: req/ivalid/pc_en=%b%b%b instr=%h expected 010 instr=%h",
                 imem_req, instr_valid, pc_en, instr, exp_q[0]);
      end
      noise();
      instr_ready = (i == yd);
    end
  endtask

  task automatic do_exec(input int dd, input logic [1:0] sel);
    for (int i = 0; i <= dd; i++) begin
      @(negedge clk);
      n_vec++;
      if ({imem_req, instr_valid, pc_en} !== 3'b000 || instr !== exp_q[0]) begin
        n_err++;
        $display("FAIL exec_wait: req/ivalid/pc_en=%b%b%b instr=%h expected 000 instr=%h",
                 imem_req, instr_valid, pc_en, instr, exp_q[0]);
      end
      noise();
      ex_done = (i == dd);
      if (i == dd) ex_pc_sel = PC_sel_e'(sel);
    end
  endtask

  task automatic do_update(input logic [1:0] sel);
    @(negedge clk);
    n_vec++;
    if ({imem_req, instr_valid, pc_en} !== 3'b001 || pc_sel !== exp_sel(sel) || retired !== model_retired) begin
      n_err++;
      $display("FAIL pc_update: req/ivalid/pc_en=%b%b%b pc_sel=%0d retired=%h expected 001 pc_sel=%0d retired=%h",
               imem_req, instr_valid, pc_en, pc_sel, retired, exp_sel(sel), model_retired);
    end
    noise();
    void'(exp_q.pop_front());
    model_retired = model_retired + 32'd1;
    model_pc = (exp_sel(sel) == 2'b00) ? model_pc + 32'd4 : $urandom;
    pc = model_pc;
  endtask

  task automatic run_instr(input int gd, input int rd, input int yd, input int dd, input logic [1:0] sel);
    do_req(gd);
    do_wait(rd, $urandom);
    do_issue(yd);
    do_exec(dd, sel);
    do_update(sel);
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    pc = 32'h0;
    model_pc = 32'h0;
    model_retired = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if ({imem_req, instr_valid, pc_en, err} !== 4'b0000 || pc_sel !== PC_4 || retired !== 32'd0 ||
          instr !== 32'd0 || imem_addr !== pc) begin
        n_err++;
        $display("FAIL reset_outputs: req/ivalid/pc_en/err=%b%b%b%b pc_sel=%0d retired=%h instr=%h addr=%h, expected 0000 0 0 0 %h",
                 imem_req, instr_valid, pc_en, err, pc_sel, retired, instr, imem_addr, pc);
      end
      noise();
    end
    @(negedge clk);
    quiet();
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (imem_req !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: imem_req=%b expected 1", imem_req);
    end
  endtask

  task automatic test_sequential();
    run_instr(0, 0, 0, 0, 2'b00);
  endtask

  task automatic test_grant_stall();
    run_instr(5, 1, 0, 0, 2'b00);
  endtask

  task automatic test_branch_jump();
    run_instr(0, 0, 1, 2, 2'b01);
    run_instr(1, 2, 0, 0, 2'b10);
    run_instr(0, 0, 0, 1, 2'b11);
  endtask

  task automatic test_boundary();
    run_instr(0, TIMEOUT - 1, 0, 0, 2'b00);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++)
      run_instr($urandom_range(0, 3), $urandom_range(0, TIMEOUT - 1), $urandom_range(0, 3),
                $urandom_range(0, 3), 2'($urandom_range(0, 3)));
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    model_retired = 32'hFFFF_FFFF;
    run_instr(0, 0, 0, 0, 2'b00);
    run_instr(0, 0, 0, 0, 2'b00);
  endtask

  task automatic test_reset_mid();
    do_req(0);
    do_wait(1, $urandom);
    do_issue(0);
    @(negedge clk);
    quiet();
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({imem_req, instr_valid, pc_en, err} !== 4'b0000 || pc_sel !== PC_4 || retired !== 32'd0 || instr !== 32'd0) begin
      n_err++;
      $display("FAIL reset_async: req/ivalid/pc_en/err=%b%b%b%b pc_sel=%0d retired=%h instr=%h expected 0000 0 0 0",
               imem_req, instr_valid, pc_en, err, pc_sel, retired, instr);
    end
    exp_q.delete();
    model_retired = 32'd0;
    for (int i = 0; i < 3; i++) begin
      noise();
      ex_done = 1'b1;
      @(negedge clk);
      n_vec++;
      if (pc_en !== 1'b0 || imem_req !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold: pc_en=%b imem_req=%b expected 0 0", pc_en, imem_req);
      end
    end
    quiet();
    rst = 1'b0;
    run_instr(0, 0, 0, 0, 2'b01);
  endtask

  task automatic test_timeout();
    do_req(0);
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      n_vec++;
      if ({imem_req, err} !== 2'b00) begin
        n_err++;
        $display("FAIL timeout_early: imem_req=%b err=%b expected 0 0 (wait cycle %0d)", imem_req, err, i);
      end
      noise();
      imem_rvalid = 1'b0;
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_vec++;
      if ({imem_req, instr_valid, pc_en, err} !== 4'b0001) begin
        n_err++;
        $display("FAIL timeout_err: req/ivalid/pc_en/err=%b%b%b%b expected 0001 (cycle %0d after timeout)",
                 imem_req, instr_valid, pc_en, err, i);
      end
      noise();
      imem_rvalid = 1'b1;
      instr_ready = 1'b1;
      ex_done = 1'b1;
    end
    quiet();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    quiet();
    test_reset();
    test_sequential();
    test_grant_stall();
    test_branch_jump();
    test_boundary();
    test_random();
    test_wrap();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
